// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding, default width
// and the counter sizing helper.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_WIDTH     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter must hold WIDTH-1; a 1-bit counter is kept for WIDTH=1.
  function automatic int cnt_bits(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full adder used as the datapath of the serial adder.
// Purely combinational, zero latency, no flow control.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ z;
  assign cout = (x & y) | (z & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one bit per cycle; optional ovf via SERIAL_ADDER_OVF_EN.
// Latency: WIDTH+1 cycles from the start-sampling edge to the done pulse.
// No backpressure: start is only honoured in IDLE/DONE and ignored while busy.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_bits(WIDTH);

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             load;
  logic             step;
  logic             last;
  logic             fa_s;
  logic             fa_c;

  fa_cell u_fa (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .z    (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // Result bits enter at the MSB so that after WIDTH steps bit 0 sits at LSB.
  always_comb begin
    acc_nxt            = acc >> 1;
    acc_nxt[WIDTH-1]   = fa_s;
  end

  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b;
      acc   <= '0;
      carry <= cin;
      cnt   <= '0;
    end else if (step) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      acc   <= acc_nxt;
      carry <= fa_c;
      cnt   <= cnt + CW'(1);
    end
  end

  // Visible result only changes on the RUN->DONE step; carry holds the
  // carry into the MSB during that final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (step && last) begin
      sum  <= acc_nxt;
      cout <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
      ovf  <= carry ^ fa_c;
`endif
    end
  end

  a_busy_done_excl: assert property (@(posedge clk) !(busy && done));

  a_done_single: assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8: vector table plus sequences
// for ignored start, mid-run reset, reset priority and back-to-back starts.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] prev_sum;
  logic       prev_cout;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge one cycle after done.
  task automatic run_vec(input int idx, input vec_t v);
    int bad_busy;
    int early_done;
    int not_held;
    bad_busy   = 0;
    early_done = 0;
    not_held   = 0;
    start = 1'b1;
    a     = v.a;
    b     = v.b;
    cin   = v.cin;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        a     = ~v.a;
        b     = ~v.b;
        cin   = ~v.cin;
      end
      if (busy !== 1'b1) bad_busy++;
      if (done !== 1'b0) early_done++;
      if (sum !== prev_sum || cout !== prev_cout) not_held++;
    end
    chk($sformatf("v%0d busy_8_cycles", idx), bad_busy, 0);
    chk($sformatf("v%0d no_early_done", idx), early_done, 0);
    chk($sformatf("v%0d result_held_in_run", idx), not_held, 0);
    @(negedge clk);
    chk($sformatf("v%0d done_at_9", idx), {busy, done}, 2'b01);
    chk($sformatf("v%0d sum", idx), sum, v.s);
    chk($sformatf("v%0d cout", idx), cout, v.co);
`ifdef SERIAL_ADDER_OVF_EN
    chk($sformatf("v%0d ovf", idx), ovf, v.ov);
`endif
    @(negedge clk);
    chk($sformatf("v%0d idle_after_done", idx), {busy, done}, 2'b00);
    chk($sformatf("v%0d sum_held_idle", idx), sum, v.s);
    prev_sum  = v.s;
    prev_cout = v.co;
  endtask

  initial begin
    vec_t vt[9];
    int   dcnt;
    int   dcyc;

    vt[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, s: 8'h10, co: 1'b0, ov: 1'b0};
    vt[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b0};
    vt[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, co: 1'b1, ov: 1'b0};
    vt[3] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, s: 8'h80, co: 1'b0, ov: 1'b1};
    vt[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b1};
    vt[5] = '{a: 8'h00, b: 8'h00, cin: 1'b1, s: 8'h01, co: 1'b0, ov: 1'b0};
    vt[6] = '{a: 8'hA5, b: 8'h5A, cin: 1'b0, s: 8'hFF, co: 1'b0, ov: 1'b0};
    vt[7] = '{a: 8'h3C, b: 8'hC4, cin: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b0};
    vt[8] = '{a: 8'h55, b: 8'h55, cin: 1'b1, s: 8'hAB, co: 1'b0, ov: 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy_done", {busy, done}, 2'b00);
    chk("reset sum", sum, 8'h00);
    chk("reset cout", cout, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("reset ovf", ovf, 1'b0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("idle no start", {busy, done}, 2'b00);
    prev_sum  = 8'h00;
    prev_cout = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_vec(i, vt[i]);
    end

    // start and new operands during RUN must be ignored
    dcnt  = 0;
    dcyc  = 0;
    start = 1'b1;
    a     = 8'h0F;
    b     = 8'h01;
    cin   = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 3) begin
        start = 1'b1;
        a     = 8'h22;
        b     = 8'h33;
        cin   = 1'b1;
      end
      if (c == 4) start = 1'b0;
      if (done === 1'b1) begin
        dcnt++;
        dcyc = c;
      end
      if (c == 9) begin
        chk("ignore sum", sum, 8'h10);
        chk("ignore cout", cout, 1'b0);
      end
    end
    chk("ignore done_count", dcnt, 1);
    chk("ignore done_cycle", dcyc, 9);

    // reset in RUN cycle 4 aborts without a done pulse
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h01;
    cin   = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    chk("abort busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy_done", {busy, done}, 2'b00);
    chk("abort sum", sum, 8'h00);
    chk("abort cout", cout, 1'b0);
    dcnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) dcnt++;
    end
    chk("abort stays_idle", dcnt, 0);

    // reset wins over start in the same cycle
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h01;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_priority busy", busy, 1'b0);

    // start held high: back-to-back additions every 9 cycles
    dcnt  = 0;
    start = 1'b1;
    a     = 8'h03;
    b     = 8'h04;
    cin   = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
      if (c == 9) begin
        chk("b2b first done", done, 1'b1);
        chk("b2b first sum", sum, 8'h07);
        a = 8'h10;
        b = 8'h20;
      end
      if (c == 10) chk("b2b restart busy", busy, 1'b1);
      if (c == 18) begin
        chk("b2b second done", done, 1'b1);
        chk("b2b second sum", sum, 8'h30);
        chk("b2b second cout", cout, 1'b0);
        start = 1'b0;
      end
      if (c == 19) chk("b2b idle after", {busy, done}, 2'b00);
    end
    chk("b2b done_count", dcnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 1..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin an addition.
REQ-005 SHALL have port a  input  WIDTH  first operand.
REQ-006 SHALL have port b  input  WIDTH  second operand.
REQ-007 SHALL have port cin  input  1  carry-in.
REQ-008 SHALL have port busy  output  1  high while bits are being processed.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-010 SHALL have port sum  output  WIDTH  registered sum.
REQ-011 SHALL have port cout  output  1  registered carry-out.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL, in IDLE or DONE with start=1, latch a, b and cin into internal shift/carry registers, clear bit counter, and enter RUN.
REQ-014 SHALL, in DONE with start=0, return to IDLE; in IDLE with start=0, stay in IDLE.
REQ-015 SHALL, in each RUN cycle, add operand LSBs plus carry register through one full-adder cell, shift result bit into the internal sum register MSB-side, shift operands right, update carry register, and increment counter.
REQ-016 SHALL leave RUN for DONE after exactly WIDTH RUN cycles (counter reaches WIDTH-1 in the final RUN cycle).
REQ-017 SHALL update sum and cout only on the RUN->DONE transition; both hold their values at all other times until the next completion.
REQ-018 SHALL assert busy exactly in RUN and done exactly in DONE; latency from the edge sampling start to done high is WIDTH+1 cycles.
REQ-019 SHALL ignore start (and changes to a, b, cin) while in RUN.
REQ-020 SHALL support back-to-back operation: start=1 in the DONE cycle begins a new addition without an IDLE cycle.
REQ-021 SHALL produce modulo-2^WIDTH sum with carry out of the MSB on cout (e.g. all-ones + 1 wraps to 0, cout=1).
REQ-022 SHALL work for WIDTH=1 (single RUN cycle).

Reset
REQ-023 SHALL, when rst=1 at a clock edge, force state IDLE, busy=0, done=0, sum=0, cout=0, counter, carry and shift registers to 0.
REQ-024 SHALL abort any in-progress addition on reset without producing done; rst has priority over start in the same cycle.

Configuration
REQ-025 SHALL, with macro SERIAL_ADDER_OVF_EN defined, add output port ovf (1 bit): signed overflow (carry into MSB XOR carry out of MSB), updated with sum/cout and reset to 0.
REQ-026 SHALL, without SERIAL_ADDER_OVF_EN, have no ovf port and no overflow logic; all other behaviour identical.

Structure
REQ-027 SHALL take FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default WIDTH from shared package serial_adder_pkg.
REQ-028 SHALL instantiate one sub-module fa_cell (inputs x, y, z; outputs s, cout; purely combinational) for the per-bit addition.

Verification
REQ-029 SHALL cover: WIDTH=8, a=0x0F, b=0x01, cin=0, start one cycle -> busy high 8 cycles, done at cycle 9, sum=0x10, cout=0.
REQ-030 SHALL cover: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-031 SHALL cover: start pulsed with new operands during RUN -> ignored; result matches first operands, done occurs once.
REQ-032 SHALL cover: rst asserted at RUN cycle 4 -> next cycle IDLE, busy=0, sum=0, cout=0, no done pulse.
REQ-033 SHALL cover: start held high continuously with 0x03+0x04 then 0x10+0x20 -> done pulses every 9 cycles, sums 0x07 then 0x30.
REQ-034 SHALL cover, with SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
